ss_sched: RTL and testbench
===========================

// Module: ss_sched
// PURPOSE
// Round-robin burst scheduler sharing one 64-bit bus master between NSLOT stream slots.
// Slots are channel FIFO ports: src-FIFO write sides and dst-FIFO read sides.
// Grants one slot at a time and sequences a burst of up to BURST_LEN beats.
// Generates per-slot ss_xfer/ss_last strobes; honours each slot's ss_start/ss_stop/ss_end flow control.
// PARAMETERS
// NSLOT      4   number of stream slots (2..8)
// SLOT_W     2   width of slot index, >= log2(NSLOT)
// BURST_LEN  8   max beats per grant (1..2**CNT_W)
// CNT_W      4   beat counter width
// PORTS
// wb_clk_i   in   1        single clock; all logic rising-edge
// wb_rst_i   in   1        asynchronous, active-high reset
// slot_en    in   NSLOT    per-slot enable (channel running)
// ss_start   in   NSLOT    slot ready to start a burst
// ss_stop    in   NSLOT    slot must pause now (FIFO almost full)
// ss_end     in   NSLOT    current word of slot is its final word
// m_ack      in   1        bus master accepted one beat this cycle
// m_req      out  1        beat request to bus master
// m_slot     out  SLOT_W   index of granted slot
// m_first    out  1        current request is first beat of burst
// ss_xfer    out  NSLOT    one-hot beat strobe to granted slot
// ss_last    out  NSLOT    marks final beat of burst, qualified by ss_xfer
// busy       out  1        scheduler not in IDLE
// BEHAVIOUR
// Reset (async): state=IDLE, grant=0, last_grant=NSLOT-1, cnt=0.
// Reset: all outputs 0, m_slot=0. Reset mid-burst abandons the burst; no strobes issued.
// req[i] = slot_en[i] & ss_start[i] & ~ss_stop[i].
// States IDLE -> XFER -> DONE -> IDLE.
// IDLE
//   If req!=0: register grant = first set req index searching last_grant+1 upward, wrapping.
//   Then cnt<=0 -> XFER. Latency: req high at cycle N gives m_req high at N+1.
// XFER
//   m_req = ~ss_stop[grant] & slot_en[grant]. m_slot=grant.
//   m_first = (cnt==0).
//   beat = m_req & m_ack. m_ack while m_req=0 is ignored; no strobe, no count.
//   ss_xfer[grant] = beat (combinational, same cycle as m_ack); other bits 0.
//   last = beat & ((cnt==BURST_LEN-1) | ss_end[grant]).
//   ss_last[grant] = last.
//   On beat: cnt<=cnt+1. On last: -> DONE.
//   ss_stop[grant]=1 with no beat possible (gated): -> DONE. Burst closes early; no ss_last emitted.
//   slot_en[grant] falls: -> DONE immediately, same rule as stop.
//   ss_stop and m_ack in same cycle: stop wins (m_req low, ack ignored).
// DONE
//   One idle cycle, all strobes 0. last_grant<=grant -> IDLE.
//   Guarantees >=1 gap cycle between bursts.
// busy = (state!=IDLE).
// Fairness: a slot granted last is searched last next round.
// Slots with slot_en=0 never granted.
// Counter never wraps: max value BURST_LEN-1 before DONE.
// All outputs derived from registered state plus current-cycle inputs. No combinational path from m_ack to m_req.
// TESTING
// T1: reset, req slot1 only, m_ack held 1.
//   -> m_req one cycle after req, m_slot=1, 8 ss_xfer[1] pulses.
//   -> ss_last[1] on 8th; 1-cycle gap; busy falls.
// T2: slots 0,2,3 request continuously.
//   -> grant order 0,2,3,0,2,3; each 8 beats.
// T3: slot0 burst, ss_end[0]=1 on beat 3.
//   -> ss_last[0] with beat 3, DONE; next grant per RR.
// T4: ss_stop[grant] raised after beat 5 while m_ack=1.
//   -> no further strobes, no ss_last.
//   -> burst closed; slot re-granted later with m_first=1.
// T5: m_ack pulses while m_req=0 (IDLE/DONE/stopped).
//   -> no ss_xfer; cnt unchanged.
// T6: assert wb_rst_i mid-burst (beat 4) for one cycle.
//   -> outputs 0 asynchronously; after release slot0 has priority.

Source files
------------

// File: rtl/ss_sched.sv
// Round-robin burst scheduler: shares one bus master between NSLOT stream slots,
// granting one slot at a time for a burst of up to BURST_LEN beats.
module ss_sched #(
    parameter int NSLOT     = 4,
    parameter int SLOT_W    = 2,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NSLOT-1:0]  slot_en,
    input  logic [NSLOT-1:0]  ss_start,
    input  logic [NSLOT-1:0]  ss_stop,
    input  logic [NSLOT-1:0]  ss_end,
    input  logic              m_ack,
    output logic              m_req,
    output logic [SLOT_W-1:0] m_slot,
    output logic              m_first,
    output logic [NSLOT-1:0]  ss_xfer,
    output logic [NSLOT-1:0]  ss_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   grant_q, grant_d;
    logic [SLOT_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NSLOT-1:0]    req;
    logic [SLOT_W-1:0]   rr_pick;
    logic                rr_found;
    logic                beat;
    logic                last;

    assign req = slot_en & ss_start & ~ss_stop;

    // Search starts just after the previous winner so it is considered last.
    always_comb begin
        int                idx;
        logic [SLOT_W-1:0] idx_s;
        rr_pick  = '0;
        rr_found = 1'b0;
        idx      = 0;
        idx_s    = '0;
        for (int k = 1; k <= NSLOT; k++) begin
            idx   = (int'(last_grant_q) + k) % NSLOT;
            idx_s = SLOT_W'(idx);
            if (!rr_found && req[idx_s]) begin
                rr_found = 1'b1;
                rr_pick  = idx_s;
            end
        end
    end

    always_comb begin
        m_req   = 1'b0;
        m_slot  = '0;
        m_first = 1'b0;
        ss_xfer = '0;
        ss_last = '0;
        beat    = 1'b0;
        last    = 1'b0;
        if (state_q == XFER) begin
            m_req   = ~ss_stop[grant_q] & slot_en[grant_q];
            m_slot  = grant_q;
            m_first = (cnt_q == '0);
            beat    = m_req & m_ack;
            last    = beat & ((cnt_q == CNT_W'(BURST_LEN - 1)) | ss_end[grant_q]);
            if (beat) begin
                ss_xfer = NSLOT'(1) << grant_q;
            end
            if (last) begin
                ss_last = NSLOT'(1) << grant_q;
            end
        end
    end

    assign busy = (state_q != IDLE);

    // A gated request (stop or disable) closes the burst without ss_last.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last || !m_req) begin
                    state_d = DONE;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SLOT_W'(NSLOT - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ss_sched.sv
// Self-checking bench for ss_sched: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural round-robin model.
module tb_ss_sched;

    localparam int NSLOT     = 4;
    localparam int SLOT_W    = 2;
    localparam int BURST_LEN = 8;
    localparam int CNT_W     = 4;
    localparam int VW        = 1 + SLOT_W + 1 + NSLOT + NSLOT + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NSLOT-1:0]  slot_en  = '0;
    logic [NSLOT-1:0]  ss_start = '0;
    logic [NSLOT-1:0]  ss_stop  = '0;
    logic [NSLOT-1:0]  ss_end   = '0;
    logic              m_ack    = 1'b0;
    logic              m_req;
    logic [SLOT_W-1:0] m_slot;
    logic              m_first;
    logic [NSLOT-1:0]  ss_xfer;
    logic [NSLOT-1:0]  ss_last;
    logic              busy;

    int errors = 0;
    int checks = 0;

    ss_sched #(
        .NSLOT(NSLOT), .SLOT_W(SLOT_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .slot_en(slot_en), .ss_start(ss_start), .ss_stop(ss_stop), .ss_end(ss_end),
        .m_ack(m_ack), .m_req(m_req), .m_slot(m_slot), .m_first(m_first),
        .ss_xfer(ss_xfer), .ss_last(ss_last), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [VW-1:0] obs = {m_req, m_slot, m_first, ss_xfer, ss_last, busy};

    // Behavioural model: a burst in progress on some slot, a gap cycle, or waiting.
    bit          mdl_burst;
    bit          mdl_gap;
    int          mdl_slot;
    int          mdl_beats;
    int          mdl_last_served;
    bit          mdl_beat;
    bit          mdl_fin;
    logic [VW-1:0] exp_vec;

    function automatic int rr_choose(input logic [NSLOT-1:0] want, input int after);
        for (int d = 1; d <= NSLOT; d++) begin
            if (want[(after + d) % NSLOT]) return (after + d) % NSLOT;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mdl_burst       = 1'b0;
        mdl_gap         = 1'b0;
        mdl_slot        = 0;
        mdl_beats       = 0;
        mdl_last_served = NSLOT - 1;
    endtask

    task automatic model_eval();
        logic [NSLOT-1:0]  xf;
        logic [NSLOT-1:0]  ls;
        logic [SLOT_W-1:0] gs;
        bit r;
        xf       = '0;
        ls       = '0;
        mdl_beat = 1'b0;
        mdl_fin  = 1'b0;
        if (mdl_burst) begin
            r        = slot_en[mdl_slot] && !ss_stop[mdl_slot];
            mdl_beat = r && m_ack;
            if (mdl_beat) xf[mdl_slot] = 1'b1;
            if (mdl_beat && (mdl_beats == BURST_LEN - 1 || ss_end[mdl_slot])) ls[mdl_slot] = 1'b1;
            mdl_fin  = (ls != '0) || !r;
            gs       = SLOT_W'(mdl_slot);
            exp_vec  = {r, gs, (mdl_beats == 0), xf, ls, 1'b1};
        end else if (mdl_gap) begin
            exp_vec = {{(VW-1){1'b0}}, 1'b1};
        end else begin
            exp_vec = '0;
        end
    endtask

    task automatic model_advance();
        int p;
        if (mdl_burst) begin
            if (mdl_fin) begin
                mdl_burst = 1'b0;
                mdl_gap   = 1'b1;
            end else if (mdl_beat) begin
                mdl_beats++;
            end
        end else if (mdl_gap) begin
            mdl_gap         = 1'b0;
            mdl_last_served = mdl_slot;
        end else begin
            p = rr_choose(slot_en & ss_start & ~ss_stop, mdl_last_served);
            if (p >= 0) begin
                mdl_burst = 1'b1;
                mdl_slot  = p;
                mdl_beats = 0;
            end
        end
    endtask

    task automatic clear_inputs();
        slot_en  = '0;
        ss_start = '0;
        ss_stop  = '0;
        ss_end   = '0;
        m_ack    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b want %b", obs, {VW{1'b0}});
        end
        slot_en  = '1;
        ss_start = '1;
        m_ack    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b want %b", obs, {VW{1'b0}});
        end
        clear_inputs();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_slot();
        int pulses = 0;
        int last_cyc = -1;
        int first_req = -1;
        bit busy10 = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            slot_en  = '1;
            ss_start = (cyc <= 8) ? 4'b0010 : 4'b0000;
            m_ack    = 1'b1;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL single_slot cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (ss_xfer[1]) pulses++;
            if (ss_last[1]) last_cyc = cyc;
            if (m_req && first_req < 0) first_req = cyc;
            if (cyc == 10) busy10 = busy;
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (pulses !== 8) begin
            errors++;
            $display("[TB] FAIL single_pulses: got %0d want 8", pulses);
        end
        checks++;
        if (last_cyc !== 8) begin
            errors++;
            $display("[TB] FAIL single_last_cycle: got %0d want 8", last_cyc);
        end
        checks++;
        if (first_req !== 1) begin
            errors++;
            $display("[TB] FAIL single_req_latency: got %0d want 1", first_req);
        end
        checks++;
        if (busy10 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_busy_fall: got %b want 0", busy10);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 2, 3, 0, 2, 3};
        int seen [$];
        int beats_per [$];
        int cur = 0;
        do_reset();
        for (int cyc = 0; cyc < 60; cyc++) begin
            slot_en  = '1;
            ss_start = 4'b1101;
            m_ack    = 1'b1;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL round_robin cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (ss_xfer != '0 && m_first) begin
                seen.push_back(int'(m_slot));
                cur = 0;
            end
            if (ss_xfer != '0) cur++;
            if (ss_last != '0) beats_per.push_back(cur);
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (seen.size() !== 6) begin
            errors++;
            $display("[TB] FAIL rr_grant_count: got %0d want 6", seen.size());
        end
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== order[i]) begin
                errors++;
                $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", i, seen[i], order[i]);
            end
        end
        for (int i = 0; i < beats_per.size(); i++) begin
            checks++;
            if (beats_per[i] !== BURST_LEN) begin
                errors++;
                $display("[TB] FAIL rr_burst_len[%0d]: got %0d want %0d", i, beats_per[i], BURST_LEN);
            end
        end
    endtask

    task automatic test_end_early();
        int beats0 = 0;
        int last_at = -1;
        int seen [$];
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            slot_en  = '1;
            ss_start = 4'b0011;
            m_ack    = 1'b1;
            ss_end   = (mdl_burst && mdl_slot == 0 && mdl_beats == 2) ? 4'b0001 : 4'b0000;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL end_early cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (ss_xfer[0]) beats0++;
            if (ss_last[0]) last_at = beats0;
            if (ss_xfer != '0 && m_first) seen.push_back(int'(m_slot));
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (last_at !== 3 || beats0 !== 3) begin
            errors++;
            $display("[TB] FAIL end_early_last: got last at %0d of %0d beats want 3 of 3", last_at, beats0);
        end
        checks++;
        if (seen.size() < 2 || seen[1] !== 1) begin
            errors++;
            $display("[TB] FAIL end_early_next_grant: got %0d grants want second grant slot 1", seen.size());
        end
    endtask

    task automatic test_stop();
        int xf_early = 0;
        int last_early = 0;
        bit refirst = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 22; cyc++) begin
            slot_en  = '1;
            ss_start = 4'b0001;
            m_ack    = 1'b1;
            ss_stop  = (cyc >= 6 && cyc < 10) ? 4'b0001 : 4'b0000;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL stop cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (cyc < 10 && ss_xfer != '0) xf_early++;
            if (cyc < 10 && ss_last != '0) last_early++;
            if (cyc == 11 && m_req && m_first && ss_xfer == 4'b0001) refirst = 1'b1;
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (xf_early !== 5 || last_early !== 0) begin
            errors++;
            $display("[TB] FAIL stop_strobes: got %0d beats %0d lasts want 5 beats 0 lasts", xf_early, last_early);
        end
        checks++;
        if (refirst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_regrant_first: got %b want 1", refirst);
        end
    endtask

    task automatic test_ack_ignored();
        int stray = 0;
        do_reset();
        for (int cyc = 0; cyc < 80; cyc++) begin
            slot_en  = '1;
            ss_start = ($urandom_range(0, 3) == 0) ? NSLOT'($urandom) : '0;
            ss_stop  = ($urandom_range(0, 3) == 0) ? NSLOT'($urandom) : '0;
            ss_end   = '0;
            m_ack    = 1'b1;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL ack_ignored cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (ss_xfer != '0 && !m_req) stray++;
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL ack_without_req: got %0d strobes want 0", stray);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            slot_en  = ($urandom_range(0, 7) == 0) ? NSLOT'($urandom) : 4'b1011;
            ss_start = NSLOT'($urandom);
            ss_stop  = ($urandom_range(0, 4) == 0) ? NSLOT'($urandom) : '0;
            ss_end   = ($urandom_range(0, 5) == 0) ? NSLOT'($urandom) : '0;
            m_ack    = ($urandom_range(0, 3) != 0);
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit slot0_first = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 5; cyc++) begin
            slot_en  = '1;
            ss_start = 4'b0011;
            m_ack    = 1'b1;
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (cyc < 4) begin
                model_advance();
                @(posedge clk);
                @(negedge clk);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: got %b want %b", obs, {VW{1'b0}});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            model_eval();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL reset_mid_post cycle %0d: got %b want %b", cyc, obs, exp_vec);
            end
            if (cyc == 1 && m_first && ss_xfer == 4'b0001 && m_slot == 2'd0) slot0_first = 1'b1;
            model_advance();
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (slot0_first !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_priority: got %b want slot0 granted first", slot0_first);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_slot();
        test_round_robin();
        test_end_early();
        test_stop();
        test_ack_ignored();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
